// File: rtl/cvmcu_probe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cvmcu_probe_pkg
//  Description : Shared types and constants for the probe event capture block:
//                default widths/depth, capture FSM state encoding, the event
//                record layout and a saturating counter helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package cvmcu_probe_pkg;

    localparam int unsigned c_DEF_STATE_W = 8;
    localparam int unsigned c_DEF_TS_W    = 16;
    localparam int unsigned c_DEF_DEPTH   = 8;
    localparam logic [7:0]  c_DROP_MAX    = 8'hFF;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } probe_state_e;

    // Event record as seen at the default widths; the flat FIFO word in the
    // top keeps the same field order {locked, state, ts}.
    typedef struct packed {
        logic                     locked;
        logic [c_DEF_STATE_W-1:0] state;
        logic [c_DEF_TS_W-1:0]    ts;
    } probe_evt_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == c_DROP_MAX) ? v : v + 8'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cvmcu_probe_evt_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : cvmcu_probe_evt_fifo
//  Description : Synchronous single-clock FIFO holding captured probe events.
//                A push while full is accepted only if a pop happens in the
//                same cycle. Head data reads as zero while empty so outputs
//                are never undefined.
//  Ports       : clk, reset_n (sync, active-low), i_push, i_pop, i_data,
//                o_data (head), o_full, o_empty, o_level (occupancy)
//  Revision    : 1.0 - initial release
// ============================================================================
module cvmcu_probe_evt_fifo #(
    parameter int unsigned DW    = 25,
    parameter int unsigned DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         i_push,
    input  logic                         i_pop,
    input  logic [DW-1:0]                i_data,
    output logic [DW-1:0]                o_data,
    output logic                         o_full,
    output logic                         o_empty,
    output logic [$clog2(DEPTH+1)-1:0]   o_level
);

    localparam int unsigned c_AW = $clog2(DEPTH);
    localparam int unsigned c_LW = $clog2(DEPTH + 1);
    localparam logic [c_LW-1:0] c_FULL_LVL = c_LW'(DEPTH);

    logic [DW-1:0]   r_mem [DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_LW-1:0] r_count;

    logic w_full;
    logic w_empty;
    logic w_do_pop;
    logic w_do_push;

    assign w_full    = (r_count == c_FULL_LVL);
    assign w_empty   = (r_count == '0);
    assign w_do_pop  = i_pop & ~w_empty;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign w_do_push = i_push & (~w_full | w_do_pop);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_LW'(1);
                2'b01:   r_count <= r_count - c_LW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is deliberately not reset; only pointers and count are.
    always_ff @(posedge clk) begin
        if (reset_n && w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    assign o_data  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_level = r_count;

endmodule
`default_nettype wire

// File: rtl/cvmcu_probe_evt_cap.sv
`default_nettype none
// ============================================================================
//  Module      : cvmcu_probe_evt_cap
//  Description : Probe event capture. Timestamps changes of {locked_i,state_i}
//                while enabled and queues them in an event FIFO. Entering the
//                running state records one baseline event. Events arriving
//                with the FIFO full (and no pop) are dropped and counted.
//  Ports       : clk, reset_n (sync, active-low)
//                en_i, clr_i, locked_i, state_i       - control / probe inputs
//                evt_valid_o, evt_ready_i,
//                evt_locked_o, evt_state_o, evt_ts_o  - event stream (head)
//                level_o, overflow_o, drop_cnt_o      - status
//  Revision    : 1.0 - initial release
// ============================================================================
module cvmcu_probe_evt_cap
    import cvmcu_probe_pkg::*;
#(
    parameter int unsigned STATE_W = c_DEF_STATE_W,
    parameter int unsigned TS_W    = c_DEF_TS_W,
    parameter int unsigned DEPTH   = c_DEF_DEPTH
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         en_i,
    input  logic                         clr_i,
    input  logic                         locked_i,
    input  logic [STATE_W-1:0]           state_i,
    output logic                         evt_valid_o,
    input  logic                         evt_ready_i,
    output logic                         evt_locked_o,
    output logic [STATE_W-1:0]           evt_state_o,
    output logic [TS_W-1:0]              evt_ts_o,
    output logic [$clog2(DEPTH+1)-1:0]   level_o,
    output logic                         overflow_o,
    output logic [7:0]                   drop_cnt_o
);

    localparam int unsigned c_SW = STATE_W + 1;
    localparam int unsigned c_DW = c_SW + TS_W;

    probe_state_e    r_state;
    probe_state_e    w_state_nxt;
    logic [TS_W-1:0] r_ts;
    logic [c_SW-1:0] r_snap;
    logic [c_SW-1:0] w_probe;
    logic            w_push;
    logic            w_pop;
    logic            w_drop;
    logic            w_full;
    logic            w_empty;
    logic [c_DW-1:0] w_evt_in;
    logic [c_DW-1:0] w_head;
    logic            r_overflow;
    logic [7:0]      r_drop_cnt;

    assign w_probe  = {locked_i, state_i};
    assign w_evt_in = {w_probe, r_ts};

    // Free-running timestamp and last-cycle probe snapshot.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_ts    <= '0;
            r_snap  <= '0;
            r_state <= ST_IDLE;
        end else begin
            r_ts    <= r_ts + TS_W'(1);
            r_snap  <= w_probe;
            r_state <= w_state_nxt;
        end
    end

    // Capture FSM: entering RUN always records a baseline so the consumer
    // knows the starting value; afterwards only changes are recorded.
    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (en_i) begin
                    w_state_nxt = ST_RUN;
                    w_push      = 1'b1;
                end
            end
            ST_RUN: begin
                if (!en_i) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_probe != r_snap) begin
                    w_push = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_pop  = ~w_empty & evt_ready_i;
    assign w_drop = w_push & w_full & ~w_pop;

    // A drop in the same cycle as a clear restarts the count at one.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            r_drop_cnt <= clr_i ? 8'd1 : sat_inc8(r_drop_cnt);
        end else if (clr_i) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end
    end

    cvmcu_probe_evt_fifo #(
        .DW    (c_DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_evt_in),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (level_o)
    );

    assign evt_valid_o  = ~w_empty;
    assign evt_locked_o = w_head[c_DW-1];
    assign evt_state_o  = w_head[TS_W +: STATE_W];
    assign evt_ts_o     = w_head[TS_W-1:0];
    assign overflow_o   = r_overflow;
    assign drop_cnt_o   = r_drop_cnt;

endmodule
`default_nettype wire
